// File: rtl/mem_wb_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and the cache (slave).
interface mem_wb_stage_if;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    logic              mem_req;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_stall;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_err;

    modport master (
        output mem_req, mem_wr, mem_addr, mem_wdata,
        input  mem_stall, mem_done, mem_rdata, mem_err
    );

    modport slave (
        input  mem_req, mem_wr, mem_addr, mem_wdata,
        output mem_stall, mem_done, mem_rdata, mem_err
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register with a done/stall memory handshake.
// Optional MEM_TIMEOUT_EN: abandon a BUSY request after TIMEOUT_CYCLES cycles and flag err.
module mem_wb_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [15:0] ex_inc_PC,
    input  logic [15:0] ex_ALU_result,
    input  logic [15:0] ex_imm_2,
    input  logic [15:0] ex_store_data,
    input  logic [1:0]  ex_reg_src,
    input  logic        ex_reg_write,
    input  logic [2:0]  ex_write_reg,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_halt,
    mem_wb_stage_if.master mem,
    output logic        stall_out,
    output logic        wb_valid,
    output logic [15:0] wb_inc_PC,
    output logic [15:0] wb_read_data,
    output logic [15:0] wb_ALU_result,
    output logic [15:0] wb_imm_2,
    output logic [1:0]  wb_reg_src,
    output logic        wb_reg_write,
    output logic [2:0]  wb_write_reg,
    output logic        halted,
    output logic        err
);
    typedef enum logic [0:0] {IDLE, BUSY} state_t;

    state_t      state;
    logic        active;
    logic        is_mem;
    logic        illegal;
    logic        hit;
    logic        op_done;
    logic        retire;
    logic        tmo;
    logic [15:0] rd_data;

    assign active  = (state == IDLE) & ex_valid & !halted;
    assign is_mem  = ex_mem_read ^ ex_mem_write;
    assign illegal = ex_mem_read & ex_mem_write;

    assign mem.mem_req   = active & is_mem & !mem.mem_stall;
    assign mem.mem_wr    = ex_mem_write;
    assign mem.mem_addr  = ex_ALU_result;
    assign mem.mem_wdata = ex_store_data;

    assign hit     = mem.mem_req & mem.mem_done;
    assign op_done = hit | ((state == BUSY) & mem.mem_done);
    assign retire  = (active & !is_mem & !illegal) | op_done;
    assign rd_data = (op_done & ex_mem_read) ? mem.mem_rdata : 16'h0000;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;

    assign tmo = (state == BUSY) & !mem.mem_done & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Cycles spent in BUSY; zero on the first BUSY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (state == BUSY)
            cnt <= cnt + CNT_W'(1);
        else
            cnt <= '0;
    end
`else
    assign tmo = 1'b0;
`endif

    assign stall_out = (active & is_mem & !hit) | ((state == BUSY) & !mem.mem_done & !tmo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wb_valid      <= 1'b0;
            wb_inc_PC     <= '0;
            wb_read_data  <= '0;
            wb_ALU_result <= '0;
            wb_imm_2      <= '0;
            wb_reg_src    <= '0;
            wb_reg_write  <= 1'b0;
            wb_write_reg  <= '0;
            halted        <= 1'b0;
            err           <= 1'b0;
        end else begin
            wb_valid     <= retire;
            wb_reg_write <= retire & ex_reg_write & !(op_done & mem.mem_err);
            // Bubbles leave the payload fields untouched.
            if (retire) begin
                wb_inc_PC     <= ex_inc_PC;
                wb_read_data  <= rd_data;
                wb_ALU_result <= ex_ALU_result;
                wb_imm_2      <= ex_imm_2;
                wb_reg_src    <= ex_reg_src;
                wb_write_reg  <= ex_write_reg;
                if (ex_halt)
                    halted <= 1'b1;
            end
            if ((active & illegal) | (op_done & mem.mem_err) | tmo)
                err <= 1'b1;
            case (state)
                IDLE:    if (mem.mem_req & !mem.mem_done) state <= BUSY;
                BUSY:    if (mem.mem_done | tmo)          state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
